// File: rtl/sprite_pkg.sv
// Shared definitions for the animated sprite blitter.
// Holds texel field widths, the pipeline latency, the texel record type,
// the nibble-to-byte colour expansion and the sprite image pattern.
package sprite_pkg;

    localparam int unsigned NIB_W        = 4;
    localparam int unsigned ALPHA_W      = 1;
    localparam int unsigned TEXEL_W      = 3 * NIB_W + ALPHA_W;
    localparam int unsigned BLIT_LATENCY = 2;

    typedef struct packed {
        logic [NIB_W-1:0]   r;
        logic [NIB_W-1:0]   g;
        logic [NIB_W-1:0]   b;
        logic [ALPHA_W-1:0] a;
    } texel_t;

    // Replicating the nibble maps 0x0..0xF evenly onto 0x00..0xFF.
    function automatic logic [7:0] nib2byte(input logic [NIB_W-1:0] n);
        return {n, n};
    endfunction

    // Sprite image: R = column, G = row, B = frame, texel (0,0) transparent.
    function automatic texel_t pattern_texel(input int unsigned x,
                                             input int unsigned y,
                                             input int unsigned f);
        texel_t t;
        t.r = NIB_W'(x);
        t.g = NIB_W'(y);
        t.b = NIB_W'(f);
        t.a = ALPHA_W'((x != 0) || (y != 0));
        return t;
    endfunction

endpackage

// File: rtl/sprite_frame_rom.sv
// Multi-frame sprite texel ROM with a one-cycle synchronous read.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   i_addr    - {frame, row, column} texel address
//   o_texel   - registered 13-bit texel {r,g,b,a}
// The image (NUM_FRAMES*SPR_W*SPR_H texels) is the constant table produced
// by sprite_pkg::pattern_texel, addressed by the decoded address fields.
module sprite_frame_rom
    import sprite_pkg::*;
#(
    parameter int unsigned SPR_W      = 16,
    parameter int unsigned SPR_H      = 16,
    parameter int unsigned NUM_FRAMES = 4,
    localparam int unsigned XW = $clog2(SPR_W),
    localparam int unsigned YW = $clog2(SPR_H),
    localparam int unsigned FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int unsigned AW = FW + YW + XW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_addr,
    output texel_t        o_texel
);

    // Synchronous read of the texel selected by the address fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_texel <= '0;
        end else begin
            o_texel <= pattern_texel(32'(i_addr[XW-1:0]),
                                     32'(i_addr[XW +: YW]),
                                     32'(i_addr[AW-1 -: FW]));
        end
    end

endmodule

// File: rtl/sprite_anim_blitter.sv
// Animated, positionable, optionally mirrored sprite composited over a
// background pixel stream with a fixed two-cycle latency.
// Ports:
//   clk, rst                 - pixel clock, asynchronous active-high reset
//   pix_valid, ix, iy        - beam position and active-area flag
//   pos_x, pos_y             - sprite top-left corner
//   vsync_tick, anim_en      - frame pulse and animation enable
//   flip_x                   - horizontal mirror
//   bg_r, bg_g, bg_b         - background pixel for the same beam position
//   oR, oG, oB, mask         - composited pixel and sprite-drawn flag
//   o_valid                  - pix_valid delayed by two cycles
//   frame_idx                - current animation frame
module sprite_anim_blitter
    import sprite_pkg::*;
#(
    parameter int unsigned SPR_W      = 16,
    parameter int unsigned SPR_H      = 16,
    parameter int unsigned NUM_FRAMES = 4,
    parameter int unsigned FRAME_HOLD = 8,
    parameter int unsigned COORD_W    = 11,
    localparam int unsigned FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] ix,
    input  logic [COORD_W-1:0] iy,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               vsync_tick,
    input  logic               anim_en,
    input  logic               flip_x,
    input  logic [7:0]         bg_r,
    input  logic [7:0]         bg_g,
    input  logic [7:0]         bg_b,
    output logic [7:0]         oR,
    output logic [7:0]         oG,
    output logic [7:0]         oB,
    output logic               mask,
    output logic               o_valid,
    output logic [FW-1:0]      frame_idx
);

    localparam int unsigned XW  = $clog2(SPR_W);
    localparam int unsigned YW  = $clog2(SPR_H);
    localparam int unsigned AW  = FW + YW + XW;
    localparam int unsigned DW  = COORD_W + 1;
    localparam int unsigned HCW = 8;

    logic [DW-1:0]  w_rx;
    logic [DW-1:0]  w_ry;
    logic           w_inside;
    logic [XW-1:0]  w_tx;
    logic [AW-1:0]  w_addr;
    texel_t         w_texel;

    logic           r_inside;
    logic           r_valid;
    logic [7:0]     r_bg_r;
    logic [7:0]     r_bg_g;
    logic [7:0]     r_bg_b;
    logic [HCW-1:0] r_hold;

    // Stage 1: sprite-relative coordinates and hit test. The explicit
    // ix>=pos_x / iy>=pos_y terms keep a wrapped subtraction from hitting.
    always_comb begin
        w_rx     = DW'(ix) - DW'(pos_x);
        w_ry     = DW'(iy) - DW'(pos_y);
        w_inside = pix_valid && (ix >= pos_x) && (iy >= pos_y) &&
                   (w_rx < DW'(SPR_W)) && (w_ry < DW'(SPR_H));
        // SPR_W is a power of two, so SPR_W-1-rx is the bitwise complement.
        w_tx     = flip_x ? ~w_rx[XW-1:0] : w_rx[XW-1:0];
        w_addr   = w_inside ? {frame_idx, w_ry[YW-1:0], w_tx} : '0;
    end

    // The ROM read register lines up with the stage-1 pipeline registers.
    sprite_frame_rom #(
        .SPR_W      (SPR_W),
        .SPR_H      (SPR_H),
        .NUM_FRAMES (NUM_FRAMES)
    ) u_rom (
        .clk     (clk),
        .rst     (rst),
        .i_addr  (w_addr),
        .o_texel (w_texel)
    );

    // Stage 1 registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inside <= 1'b0;
            r_valid  <= 1'b0;
            r_bg_r   <= '0;
            r_bg_g   <= '0;
            r_bg_b   <= '0;
        end else begin
            r_inside <= w_inside;
            r_valid  <= pix_valid;
            r_bg_r   <= bg_r;
            r_bg_g   <= bg_g;
            r_bg_b   <= bg_b;
        end
    end

    // Stage 2: composite opaque texels over the background; blank when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oR      <= '0;
            oG      <= '0;
            oB      <= '0;
            mask    <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= r_valid;
            if (!r_valid) begin
                oR   <= '0;
                oG   <= '0;
                oB   <= '0;
                mask <= 1'b0;
            end else if (r_inside && (w_texel.a != '0)) begin
                oR   <= nib2byte(w_texel.r);
                oG   <= nib2byte(w_texel.g);
                oB   <= nib2byte(w_texel.b);
                mask <= 1'b1;
            end else begin
                oR   <= r_bg_r;
                oG   <= r_bg_g;
                oB   <= r_bg_b;
                mask <= 1'b0;
            end
        end
    end

    // Animation: each frame is held for FRAME_HOLD vsync ticks; anim_en=0
    // freezes the counters in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold    <= '0;
            frame_idx <= '0;
        end else if (vsync_tick && anim_en) begin
            if (r_hold == HCW'(FRAME_HOLD - 1)) begin
                r_hold    <= '0;
                frame_idx <= (frame_idx == FW'(NUM_FRAMES - 1)) ? '0
                                                                 : frame_idx + 1'b1;
            end else begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_anim_blitter.sv
// Self-checking bench for sprite_anim_blitter: a table of single-pixel
// vectors plus hand-written animation and reset sequences.
module tb_sprite_anim_blitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic [10:0] ix, iy, pos_x, pos_y;
    logic        vsync_tick, anim_en, flip_x;
    logic [7:0]  bg_r, bg_g, bg_b;
    logic [7:0]  oR, oG, oB;
    logic        mask, o_valid;
    logic [1:0]  frame_idx;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sprite_anim_blitter #(
        .SPR_W      (16),
        .SPR_H      (16),
        .NUM_FRAMES (4),
        .FRAME_HOLD (2),
        .COORD_W    (11)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .ix         (ix),
        .iy         (iy),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .vsync_tick (vsync_tick),
        .anim_en    (anim_en),
        .flip_x     (flip_x),
        .bg_r       (bg_r),
        .bg_g       (bg_g),
        .bg_b       (bg_b),
        .oR         (oR),
        .oG         (oG),
        .oB         (oB),
        .mask       (mask),
        .o_valid    (o_valid),
        .frame_idx  (frame_idx)
    );

    typedef struct {
        string       name;
        logic [10:0] ix, iy, px, py;
        logic        flip, pv;
        logic [7:0]  br, bgg, bb;
        logic [7:0]  er, eg, eb;
        logic        em, ev;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_pix(input string nm, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b, input logic m, input logic v);
        chk({nm, ".oR"},     32'(oR),      32'(r));
        chk({nm, ".oG"},     32'(oG),      32'(g));
        chk({nm, ".oB"},     32'(oB),      32'(b));
        chk({nm, ".mask"},   32'(mask),    32'(m));
        chk({nm, ".o_valid"},32'(o_valid), 32'(v));
    endtask

    // Present one pixel for a single cycle and check it two edges later.
    task automatic run_vec(input vec_t v);
        ix = v.ix; iy = v.iy; pos_x = v.px; pos_y = v.py;
        flip_x = v.flip; pix_valid = v.pv;
        bg_r = v.br; bg_g = v.bgg; bg_b = v.bb;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        @(posedge clk); #1;
        chk_pix(v.name, v.er, v.eg, v.eb, v.em, v.ev);
    endtask

    task automatic do_tick(input logic [1:0] exp, input string nm);
        vsync_tick = 1'b1;
        @(posedge clk); #1;
        vsync_tick = 1'b0;
        chk(nm, 32'(frame_idx), 32'(exp));
    endtask

    function automatic vec_t mk(input string nm, input int x, input int y,
                                input int px, input int py, input bit fl, input bit pv,
                                input int br, input int bgg, input int bb,
                                input int er, input int eg, input int eb,
                                input bit em, input bit ev);
        vec_t v;
        v.name = nm; v.ix = 11'(x); v.iy = 11'(y); v.px = 11'(px); v.py = 11'(py);
        v.flip = fl; v.pv = pv;
        v.br = 8'(br); v.bgg = 8'(bgg); v.bb = 8'(bb);
        v.er = 8'(er); v.eg = 8'(eg); v.eb = 8'(eb);
        v.em = em; v.ev = ev;
        return v;
    endfunction

    initial begin
        // Texel (x,y) at frame f: R=x, G=y, B=f, opaque except (0,0).
        vecs[0]  = mk("place",      103, 52, 100, 50, 0, 1, 'h12, 'h34, 'h56, 'h33, 'h22, 'h00, 1, 1);
        vecs[1]  = mk("right_out",  116, 52, 100, 50, 0, 1, 'h12, 'h34, 'h56, 'h12, 'h34, 'h56, 0, 1);
        vecs[2]  = mk("flip_left",  100, 50, 100, 50, 1, 1, 'h00, 'h00, 'h00, 'hFF, 'h00, 'h00, 1, 1);
        vecs[3]  = mk("flip_right", 115, 50, 100, 50, 1, 1, 'h00, 'h00, 'h00, 'h00, 'h00, 'h00, 0, 1);
        vecs[4]  = mk("transp",     100, 50, 100, 50, 0, 1, 'h12, 'h34, 'h56, 'h12, 'h34, 'h56, 0, 1);
        vecs[5]  = mk("wrap_clip",    5, 52, 1270, 50, 0, 1, 'h12, 'h34, 'h56, 'h12, 'h34, 'h56, 0, 1);
        vecs[6]  = mk("pv_gate",    103, 52, 100, 50, 0, 0, 'h12, 'h34, 'h56, 'h00, 'h00, 'h00, 0, 0);
        vecs[7]  = mk("corner",     115, 65, 100, 50, 0, 1, 'h12, 'h34, 'h56, 'hFF, 'hFF, 'h00, 1, 1);
        vecs[8]  = mk("left_out",    99, 50, 100, 50, 0, 1, 'hAA, 'hBB, 'hCC, 'hAA, 'hBB, 'hCC, 0, 1);
        vecs[9]  = mk("above_out",  103, 49, 100, 50, 0, 1, 'h01, 'h02, 'h03, 'h01, 'h02, 'h03, 0, 1);
        vecs[10] = mk("flip_mid",   107, 53, 100, 50, 1, 1, 'h12, 'h34, 'h56, 'h88, 'h33, 'h00, 1, 1);
        vecs[11] = mk("edge_clip", 2047, 52, 2040, 50, 0, 1, 'h12, 'h34, 'h56, 'h77, 'h22, 'h00, 1, 1);

        rst = 1'b1; pix_valid = 1'b0; ix = '0; iy = '0; pos_x = '0; pos_y = '0;
        vsync_tick = 1'b0; anim_en = 1'b0; flip_x = 1'b0;
        bg_r = '0; bg_g = '0; bg_b = '0;
        @(posedge clk); @(posedge clk); #1;
        chk_pix("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("reset.frame_idx", 32'(frame_idx), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Animation with FRAME_HOLD=2, NUM_FRAMES=4.
        anim_en = 1'b1;
        do_tick(2'd0, "anim_t1"); do_tick(2'd1, "anim_t2");
        do_tick(2'd1, "anim_t3"); do_tick(2'd2, "anim_t4");
        do_tick(2'd2, "anim_t5"); do_tick(2'd3, "anim_t6");
        do_tick(2'd3, "anim_t7"); do_tick(2'd0, "anim_t8");
        do_tick(2'd0, "anim_t9"); do_tick(2'd1, "anim_t10");

        // Frame 1 selects the second ROM frame (B nibble = 1).
        run_vec(mk("frame1_pix", 103, 52, 100, 50, 0, 1, 'h12, 'h34, 'h56, 'h33, 'h22, 'h11, 1, 1));

        anim_en = 1'b0;
        do_tick(2'd1, "freeze_t1"); do_tick(2'd1, "freeze_t2"); do_tick(2'd1, "freeze_t3");
        anim_en = 1'b1;
        do_tick(2'd1, "resume_t1"); do_tick(2'd2, "resume_t2");

        // Reset mid-stream, coincident with vsync_tick.
        ix = 103; iy = 52; pos_x = 100; pos_y = 50; flip_x = 1'b0;
        bg_r = 8'h12; bg_g = 8'h34; bg_b = 8'h56; pix_valid = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk_pix("pre_rst", 8'h33, 8'h22, 8'h22, 1'b1, 1'b1);
        #3;
        rst = 1'b1; vsync_tick = 1'b1;
        #1;
        chk_pix("async_rst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("async_rst.frame_idx", 32'(frame_idx), 32'd0);
        @(posedge clk); #1;
        chk("rst_vs_vsync.frame_idx", 32'(frame_idx), 32'd0);
        rst = 1'b0; vsync_tick = 1'b0; anim_en = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_1.o_valid", 32'(o_valid), 32'd0);
        @(posedge clk); #1;
        chk_pix("post_rst_2", 8'h33, 8'h22, 8'h00, 1'b1, 1'b1);
        pix_valid = 1'b0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
